// File: rtl/hazard_forward_unit_pkg.sv
// hazard_forward_unit_pkg: forwarding select codes, hazard FSM states and shared constants
package hazard_forward_unit_pkg;
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam int REG_ZERO = 0;
    typedef enum logic {IDLE, HOLD} state_t;
endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// hazard_forward_unit_fwd_select: single-operand forwarding priority, newest producer wins
module hazard_forward_unit_fwd_select
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_reg_write,
    input  logic             mem_mem_read,
    input  logic [REG_W-1:0] wb_dest,
    input  logic             wb_reg_write,
    output logic [1:0]       sel
);
    // r0 never forwards; a load in MEM has no data yet so only WB can supply it
    always_comb
        sel = (src == REG_W'(REG_ZERO)) ? FWD_RF :
              (mem_reg_write && !mem_mem_read && mem_dest == src) ? FWD_EXMEM :
              (wb_reg_write && wb_dest == src) ? FWD_MEMWB : FWD_RF;
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: EX operand forwarding plus load-use bubbles, memory freeze and stall accounting
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int REG_W      = 5,
    parameter int LU_PENALTY = 1,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC*REG_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]       id_src_valid,
    input  logic [NUM_SRC*REG_W-1:0] ex_src,
    input  logic [REG_W-1:0]         ex_dest,
    input  logic                     ex_reg_write,
    input  logic                     ex_mem_read,
    input  logic [REG_W-1:0]         mem_dest,
    input  logic                     mem_reg_write,
    input  logic                     mem_mem_read,
    input  logic                     mem_ready,
    input  logic [REG_W-1:0]         wb_dest,
    input  logic                     wb_reg_write,
    output logic [NUM_SRC*2-1:0]     fwd_sel,
    output logic                     stall,
    output logic                     bubble,
    output logic                     freeze,
    output logic                     mem_timeout,
    output logic [CNT_W-1:0]         stall_cycles
);
    localparam int FW = $clog2(TIMEOUT + 1);

    state_t        state, state_n;
    logic [1:0]    hold_cnt, hold_n;
    logic [FW-1:0] frz_cnt;
    logic          frz_raw, lu, lu_hit, fsm_stall, fsm_bubble;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        hazard_forward_unit_fwd_select #(.REG_W(REG_W)) u_sel (
            .src          (ex_src[i*REG_W +: REG_W]),
            .mem_dest     (mem_dest),
            .mem_reg_write(mem_reg_write),
            .mem_mem_read (mem_mem_read),
            .wb_dest      (wb_dest),
            .wb_reg_write (wb_reg_write),
            .sel          (fwd_sel[i*2 +: 2])
        );
    end

    assign frz_raw = mem_mem_read && !mem_ready;
    assign freeze  = rst_n && frz_raw;
    assign stall   = rst_n && (frz_raw || fsm_stall);
    assign bubble  = rst_n && fsm_bubble;

    // load-use: any valid ID operand reads the destination of a load sitting in EX
    always_comb begin
        lu_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            lu_hit |= id_src_valid[i] && (id_src[i*REG_W +: REG_W] == ex_dest);
        lu = ex_mem_read && ex_reg_write && (ex_dest != REG_W'(REG_ZERO)) && lu_hit;
    end

    // bubble sequencer; a freeze holds state and suppresses bubbles
    always_comb begin
        state_n    = state;
        hold_n     = hold_cnt;
        fsm_stall  = 1'b0;
        fsm_bubble = 1'b0;
        if (!frz_raw && (state == HOLD || lu)) begin
            fsm_stall  = 1'b1;
            fsm_bubble = 1'b1;
            if (state == HOLD) begin
                hold_n  = hold_cnt - 2'd1;
                state_n = (hold_cnt == 2'd1) ? IDLE : HOLD;
            end else if (LU_PENALTY > 1) begin
                hold_n  = 2'(LU_PENALTY - 1);
                state_n = HOLD;
            end
        end
    end

    // state, saturating freeze timer with sticky timeout, saturating stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            frz_cnt      <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state        <= state_n;
            hold_cnt     <= hold_n;
            frz_cnt      <= !frz_raw ? '0 : (frz_cnt < FW'(TIMEOUT)) ? frz_cnt + 1'b1 : frz_cnt;
            mem_timeout  <= mem_timeout || (frz_raw && frz_cnt >= FW'(TIMEOUT - 1));
            stall_cycles <= (stall && !(&stall_cycles)) ? stall_cycles + 1'b1 : stall_cycles;
        end
    end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed checks of forwarding, load-use bubbles, freeze timeout and async reset
module tb_hazard_forward_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  id_src = '0, ex_src = '0;
    logic [1:0]  id_src_valid = '0;
    logic [4:0]  ex_dest = '0, mem_dest = '0, wb_dest = '0;
    logic        ex_reg_write = 0, ex_mem_read = 0, mem_reg_write = 0, mem_mem_read = 0;
    logic        mem_ready = 0, wb_reg_write = 0;
    logic [3:0]  fwd_a, fwd_b;
    logic        stall_a, bubble_a, freeze_a, to_a, stall_b, bubble_b, freeze_b, to_b;
    logic [15:0] sc_a, sc_b;
    int          n_chk = 0, n_pass = 0;
    int          cnt_a, cnt_b, cnt_s;
    logic [15:0] sc0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.NUM_SRC(2), .REG_W(5), .LU_PENALTY(2), .TIMEOUT(4), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_valid(id_src_valid), .ex_src(ex_src),
        .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_dest(mem_dest), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_ready(mem_ready), .wb_dest(wb_dest), .wb_reg_write(wb_reg_write),
        .fwd_sel(fwd_a), .stall(stall_a), .bubble(bubble_a), .freeze(freeze_a),
        .mem_timeout(to_a), .stall_cycles(sc_a));

    hazard_forward_unit #(.NUM_SRC(2), .REG_W(5), .LU_PENALTY(3), .TIMEOUT(4), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_valid(id_src_valid), .ex_src(ex_src),
        .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_dest(mem_dest), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_ready(mem_ready), .wb_dest(wb_dest), .wb_reg_write(wb_reg_write),
        .fwd_sel(fwd_b), .stall(stall_b), .bubble(bubble_b), .freeze(freeze_b),
        .mem_timeout(to_b), .stall_cycles(sc_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu(input logic on, input logic [1:0] valid);
        ex_mem_read  = on;
        ex_reg_write = on;
        ex_dest      = on ? 5'd3 : 5'd0;
        id_src       = on ? {5'd0, 5'd3} : '0;
        id_src_valid = valid;
    endtask

    initial begin
        repeat (2) tick();
        check("rst_stall", stall_a, 0);
        check("rst_bubble", bubble_a, 0);
        check("rst_freeze", freeze_a, 0);
        check("rst_timeout", to_a, 0);
        check("rst_cycles", sc_a, 0);
        rst_n = 1'b1;
        tick();

        ex_src = {5'd0, 5'd5}; mem_dest = 5'd5; mem_reg_write = 1; wb_dest = 5'd5; wb_reg_write = 1;
        #1 check("fwd_exmem", fwd_a[1:0], 2'b01);
        mem_reg_write = 0;
        #1 check("fwd_memwb", fwd_a[1:0], 2'b10);
        ex_src = '0; mem_reg_write = 1;
        #1 check("fwd_r0", fwd_a[1:0], 2'b00);
        mem_mem_read = 1; mem_ready = 1; mem_dest = 5'd7; ex_src = {5'd7, 5'd0}; wb_dest = 5'd7;
        #1 check("fwd_load_mem", fwd_a[3:2], 2'b10);
        check("load_ready_freeze", freeze_a, 0);
        mem_mem_read = 0; mem_ready = 0; mem_reg_write = 0; wb_reg_write = 0; ex_src = '0;
        mem_dest = '0; wb_dest = '0;

        cnt_a = 0; cnt_b = 0;
        set_lu(1, 2'b01);
        for (int c = 0; c < 5; c++) begin
            #1;
            cnt_a += int'(bubble_a && stall_a);
            cnt_b += int'(bubble_b);
            tick();
            if (c == 0) set_lu(0, 2'b00);
        end
        check("lu_bubbles_p2", cnt_a, 2);
        check("lu_cycles_p2", sc_a, 2);
        check("lu_bubbles_p3", cnt_b, 3);
        set_lu(1, 2'b00);
        #1 check("lu_invalid_stall", stall_a, 0);
        set_lu(0, 2'b00);

        mem_mem_read = 1; mem_ready = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("frz_freeze", freeze_a, 1);
            check("frz_stall", stall_a, 1);
            check("frz_bubble", bubble_a, 0);
            check("frz_timeout", to_a, k >= 4);
            tick();
        end
        mem_ready = 1;
        tick();
        mem_mem_read = 0; mem_ready = 0;
        #1 check("timeout_sticky", to_a, 1);
        check("frz_released", freeze_a, 0);
        check("frz_cycles", sc_a, 7);

        cnt_b = 0; cnt_s = 0; sc0 = sc_b;
        set_lu(1, 2'b01);
        for (int c = 0; c < 7; c++) begin
            mem_mem_read = (c == 1 || c == 2);
            #1;
            cnt_b += int'(bubble_b);
            cnt_s += int'(stall_b);
            tick();
            if (c == 0) set_lu(0, 2'b00);
        end
        mem_mem_read = 0;
        check("hold_frz_bubbles", cnt_b, 3);
        check("hold_frz_stalls", cnt_s, 5);
        check("hold_frz_cycles", sc_b - sc0, 5);

        set_lu(1, 2'b01);
        tick();
        set_lu(0, 2'b00);
        #1 check("mid_hold_bubble", bubble_b, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_stall", stall_b, 0);
        check("arst_bubble", bubble_b, 0);
        check("arst_timeout", to_b, 0);
        check("arst_cycles", sc_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt_b = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            cnt_b += int'(bubble_b || stall_b);
        end
        check("post_rst_bubbles", cnt_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised successor to the pipeline forwarding logic: per-operand forwarding select for NUM_SRC source operands in EX.
- Adds sequential hazard control: load-use bubbles with configurable penalty, a full-pipeline freeze while a data-memory load is outstanding, a freeze timeout flag and a saturating stall counter.
- Sits beside the ID/EX register; drives the EX operand muxes, PC/IF-ID hold, ID/EX bubble insert and the global freeze.

Parameters:
- NUM_SRC, 2, number of source operands checked (1..4)
- REG_W, 5, register address width
- LU_PENALTY, 1, bubble cycles per load-use hazard (1..3)
- TIMEOUT, 64, consecutive freeze cycles before mem_timeout is set
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_src  in  NUM_SRC*REG_W  IF/ID source register numbers; operand i at [i*REG_W +: REG_W]
- id_src_valid  in  NUM_SRC  operand i is actually read by the instruction in ID
- ex_src  in  NUM_SRC*REG_W  ID/EX source register numbers
- ex_dest  in  REG_W  ID/EX destination
- ex_reg_write  in  1  ID/EX writes a register
- ex_mem_read  in  1  ID/EX is a load
- mem_dest  in  REG_W  EX/MEM destination
- mem_reg_write  in  1  EX/MEM writes a register
- mem_mem_read  in  1  EX/MEM is a load
- mem_ready  in  1  data memory returns load data this cycle
- wb_dest  in  REG_W  MEM/WB destination
- wb_reg_write  in  1  MEM/WB writes a register
- fwd_sel  out  NUM_SRC*2  per operand: 00 register file, 01 EX/MEM, 10 MEM/WB
- stall  out  1  hold PC and IF/ID
- bubble  out  1  load NOP into ID/EX
- freeze  out  1  hold every pipeline register
- mem_timeout  out  1  sticky, freeze lasted TIMEOUT cycles
- stall_cycles  out  CNT_W  saturating count of cycles with stall=1

Behaviour:
- Reset (rst_n=0, async): state IDLE, hold counter 0, freeze counter 0, mem_timeout 0, stall_cycles 0. stall, bubble and freeze are forced to 0 while in reset.
- Forwarding is combinational, evaluated independently per operand i, with priority top-down:
  - ex_src[i]==0 -> 00.
  - mem_reg_write && !mem_mem_read && mem_dest==ex_src[i] -> 01.
  - wb_reg_write && wb_dest==ex_src[i] -> 10.
  - otherwise -> 00.
  - The newest producer wins. A load in MEM never forwards, because its data exists only from WB.
- Freeze, combinational: freeze = mem_mem_read && !mem_ready.
  - While freeze=1: stall=1, bubble=0.
  - The FSM state and hold counter are held.
  - Freeze has priority over every load-use action.
- Load-use detection, combinational:
  - lu = ex_mem_read && ex_reg_write && ex_dest!=0 && there exists i with id_src_valid[i] && id_src[i]==ex_dest.
- FSM:
  - IDLE: if lu && !freeze, then stall=1 and bubble=1 this cycle. If LU_PENALTY>1, go to HOLD with hold counter = LU_PENALTY-1; otherwise stay in IDLE.
  - HOLD: stall=1 and bubble=1 each non-frozen cycle, decrementing the counter. When the counter reaches 1 and the cycle is not frozen, return to IDLE at the next edge.
  - In HOLD the lu input is ignored; ID/EX already holds a bubble.
- Freeze counter:
  - Increments on each freeze=1 cycle and clears on a freeze=0 cycle.
  - When it reaches TIMEOUT, mem_timeout is set and stays set until reset.
  - The counter saturates at TIMEOUT.
- stall_cycles: +1 on each cycle with stall=1, saturating at all-ones.
- Reset mid-HOLD or mid-freeze: all state returns to reset values immediately, and no residual bubble follows.
- lu coincident with freeze: only freeze acts. The hazard is re-evaluated on the first unfrozen cycle because the pipeline registers were held.

Decomposition:
- Shared package:
  - FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - State encoding IDLE/HOLD.
  - REG_ZERO constant.
- One natural sub-module, fwd_select: single-operand forwarding priority logic, instantiated NUM_SRC times in a generate loop.

Test Plan:
- Forward priority: ex_src[0]=5; mem_dest=5, mem_reg_write=1; wb_dest=5, wb_reg_write=1 -> fwd_sel[1:0]=01. Then clear mem_reg_write -> 10. Set ex_src[0]=0 with both matching -> 00.
- Load in MEM: mem_mem_read=1, mem_ready=1, mem_dest=7, ex_src[1]=7; wb_dest=7, wb_reg_write=1 -> fwd_sel[3:2]=10, freeze=0.
- Load-use, LU_PENALTY=2: ex_mem_read=1, ex_reg_write=1, ex_dest=3, id_src[0]=3, id_src_valid=01 -> stall=bubble=1 for exactly 2 cycles, stall_cycles=2. With id_src_valid=00 -> no stall.
- Freeze and timeout, TIMEOUT=4: mem_mem_read=1, mem_ready=0 for 5 cycles -> freeze=1, stall=1, bubble=0 throughout. mem_timeout rises after the 4th cycle and stays 1 after mem_ready=1.
- Freeze during HOLD, LU_PENALTY=3: trigger lu, freeze for 2 cycles in HOLD -> total bubble cycles still 3, stall asserted for 5 cycles.
- Async reset: assert rst_n=0 mid-HOLD between clock edges -> stall, bubble, mem_timeout and stall_cycles are 0 immediately, and no bubble follows after release.
